// File: rtl/car_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// car_cmd_ctrl
//
// Turns the byte stream from the UART receiver into motor commands. Frames are
// four bytes long: HEADER, CMD, VAL, CHK. CHK must equal (CMD + VAL) with 8-bit
// wrap-around. A frame is accepted only if its checksum matches and its opcode
// is 0x00..0x05. Accepted frames drive the motor direction lines and the speed
// duty value. A link-loss watchdog stops the motors when no frame is accepted
// for WDOG_CYC cycles.
//
// Ports
//   clk        in   1   system clock
//   rst        in   1   asynchronous active-high reset
//   data       in   8   received byte, valid only while rx_done = 1
//   rx_done    in   1   single-cycle strobe marking a new byte
//   motor_dir  out  4   {L_fwd, L_bwd, R_fwd, R_bwd}
//   pwm        out  1   speed PWM, common to both motors
//   speed      out  8   current duty value
//   cmd_valid  out  1   one-cycle pulse when a frame is accepted
//   frame_err  out  1   one-cycle pulse when a frame is rejected or times out
//   wdog_stop  out  1   high while the watchdog holds the motors stopped
//   num        out  32  display value {16'h0000, last_cmd, speed}
// -----------------------------------------------------------------------------
module car_cmd_ctrl #(
    parameter logic [7:0]  HEADER      = 8'hA5,
    parameter int unsigned TIMEOUT_CYC = 500000,
    parameter int unsigned WDOG_CYC    = 25000000,
    parameter int unsigned PWM_DIV     = 196
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data,
    input  logic        rx_done,
    output logic [3:0]  motor_dir,
    output logic        pwm,
    output logic [7:0]  speed,
    output logic        cmd_valid,
    output logic        frame_err,
    output logic        wdog_stop,
    output logic [31:0] num
);

    // Counter widths sized so that the terminal value (N-1) always fits.
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int WD_W  = $clog2(WDOG_CYC + 1);
    localparam int PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

    localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(WDOG_CYC - 1);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PWM_DIV - 1);

    // Motor direction encodings {L_fwd, L_bwd, R_fwd, R_bwd}.
    localparam logic [3:0] DIR_STOP  = 4'b0000;
    localparam logic [3:0] DIR_FWD   = 4'b1010;
    localparam logic [3:0] DIR_BACK  = 4'b0101;
    localparam logic [3:0] DIR_LEFT  = 4'b0110;
    localparam logic [3:0] DIR_RIGHT = 4'b1001;

    // Opcodes.
    localparam logic [7:0] OP_STOP  = 8'h00;
    localparam logic [7:0] OP_FWD   = 8'h01;
    localparam logic [7:0] OP_BACK  = 8'h02;
    localparam logic [7:0] OP_LEFT  = 8'h03;
    localparam logic [7:0] OP_RIGHT = 8'h04;
    localparam logic [7:0] OP_SPEED = 8'h05;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_VAL  = 2'd2,
        ST_CHK  = 2'd3
    } state_t;

    // Frame checksum: plain 8-bit sum, carry discarded.
    function automatic logic [7:0] frame_sum(input logic [7:0] a, input logic [7:0] b);
        return a + b;
    endfunction

    state_t            state_q, state_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [7:0]        val_q, val_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [7:0]        pcnt_q, pcnt_d;

    logic [3:0]        motor_dir_q, motor_dir_d;
    logic [7:0]        speed_q, speed_d;
    logic [7:0]        last_cmd_q, last_cmd_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              wdog_stop_q, wdog_stop_d;
    logic              pwm_q, pwm_d;
    logic [31:0]       num_q, num_d;

    logic              timeout_s;
    logic              frame_eval_s;
    logic              accept_s;
    logic              reject_s;
    logic              wd_expired_s;
    logic              pre_wrap_s;

    // Frame decision and timer status flags.
    always_comb begin
        // A byte arriving in the expiry cycle wins over the timeout.
        timeout_s    = (state_q != ST_IDLE) && !rx_done && (to_cnt_q == TO_MAX);
        frame_eval_s = (state_q == ST_CHK) && rx_done;
        accept_s     = frame_eval_s && (frame_sum(cmd_q, val_q) == data) && (cmd_q <= OP_SPEED);
        reject_s     = frame_eval_s && !accept_s;
        wd_expired_s = (wd_cnt_q == WD_MAX);
        pre_wrap_s   = (pre_q == PRE_MAX);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic. A HEADER byte seen mid-frame is ordinary data.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (rx_done && (data == HEADER)) begin
                    state_d = ST_CMD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CMD: begin
                if (rx_done) begin
                    state_d = ST_VAL;
                end else if (timeout_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CMD;
                end
            end
            ST_VAL: begin
                if (rx_done) begin
                    state_d = ST_CHK;
                end else if (timeout_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_VAL;
                end
            end
            ST_CHK: begin
                if (rx_done || timeout_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CHK;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM output logic: next values of the registered outputs.
    always_comb begin
        motor_dir_d = motor_dir_q;
        speed_d     = speed_q;
        last_cmd_d  = last_cmd_q;
        cmd_valid_d = 1'b0;
        frame_err_d = 1'b0;
        wdog_stop_d = wdog_stop_q;
        if (accept_s) begin
            last_cmd_d  = cmd_q;
            cmd_valid_d = 1'b1;
            wdog_stop_d = 1'b0;
            case (cmd_q)
                OP_STOP: begin
                    motor_dir_d = DIR_STOP;
                end
                OP_FWD: begin
                    motor_dir_d = DIR_FWD;
                    speed_d     = val_q;
                end
                OP_BACK: begin
                    motor_dir_d = DIR_BACK;
                    speed_d     = val_q;
                end
                OP_LEFT: begin
                    motor_dir_d = DIR_LEFT;
                    speed_d     = val_q;
                end
                OP_RIGHT: begin
                    motor_dir_d = DIR_RIGHT;
                    speed_d     = val_q;
                end
                OP_SPEED: begin
                    speed_d = val_q;
                end
                default: begin
                    motor_dir_d = motor_dir_q;
                end
            endcase
        end else begin
            frame_err_d = reject_s || timeout_s;
            // Link lost: hold the motors stopped but remember the speed.
            if (wd_expired_s) begin
                motor_dir_d = DIR_STOP;
                wdog_stop_d = 1'b1;
            end else begin
                wdog_stop_d = wdog_stop_q;
            end
        end
        num_d = {16'h0000, last_cmd_d, speed_d};
        pwm_d = (pcnt_q < speed_q) && (motor_dir_q != DIR_STOP);
    end

    // Next values for frame payload, timers and PWM counters.
    always_comb begin
        if ((state_q == ST_CMD) && rx_done) begin
            cmd_d = data;
        end else begin
            cmd_d = cmd_q;
        end

        if ((state_q == ST_VAL) && rx_done) begin
            val_d = data;
        end else begin
            val_d = val_q;
        end

        // Inter-byte timer only runs while a frame is in progress.
        if (rx_done || (state_q == ST_IDLE) || timeout_s) begin
            to_cnt_d = {TO_W{1'b0}};
        end else begin
            to_cnt_d = to_cnt_q + TO_W'(1'b1);
        end

        // Watchdog saturates at its terminal count.
        if (accept_s) begin
            wd_cnt_d = {WD_W{1'b0}};
        end else if (!wd_expired_s) begin
            wd_cnt_d = wd_cnt_q + WD_W'(1'b1);
        end else begin
            wd_cnt_d = wd_cnt_q;
        end

        // pcnt runs 0..254 so that speed=255 yields a constant-high output.
        if (pre_wrap_s) begin
            pre_d = {PRE_W{1'b0}};
            if (pcnt_q == 8'd254) begin
                pcnt_d = 8'd0;
            end else begin
                pcnt_d = pcnt_q + 8'd1;
            end
        end else begin
            pre_d  = pre_q + PRE_W'(1'b1);
            pcnt_d = pcnt_q;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_q       <= 8'h00;
            val_q       <= 8'h00;
            to_cnt_q    <= {TO_W{1'b0}};
            wd_cnt_q    <= {WD_W{1'b0}};
            pre_q       <= {PRE_W{1'b0}};
            pcnt_q      <= 8'h00;
            motor_dir_q <= 4'b0000;
            speed_q     <= 8'h00;
            last_cmd_q  <= 8'h00;
            cmd_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            wdog_stop_q <= 1'b0;
            pwm_q       <= 1'b0;
            num_q       <= 32'h0000_0000;
        end else begin
            cmd_q       <= cmd_d;
            val_q       <= val_d;
            to_cnt_q    <= to_cnt_d;
            wd_cnt_q    <= wd_cnt_d;
            pre_q       <= pre_d;
            pcnt_q      <= pcnt_d;
            motor_dir_q <= motor_dir_d;
            speed_q     <= speed_d;
            last_cmd_q  <= last_cmd_d;
            cmd_valid_q <= cmd_valid_d;
            frame_err_q <= frame_err_d;
            wdog_stop_q <= wdog_stop_d;
            pwm_q       <= pwm_d;
            num_q       <= num_d;
        end
    end

    assign motor_dir = motor_dir_q;
    assign pwm       = pwm_q;
    assign speed     = speed_q;
    assign cmd_valid = cmd_valid_q;
    assign frame_err = frame_err_q;
    assign wdog_stop = wdog_stop_q;
    assign num       = num_q;

endmodule

// File: tb/tb_car_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// Directed testbench for car_cmd_ctrl with short timers
// (TIMEOUT_CYC=50, WDOG_CYC=2000, PWM_DIV=1). Inputs change on the falling
// edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_car_cmd_ctrl;

    logic        clk;
    logic        rst;
    logic [7:0]  data;
    logic        rx_done;
    logic [3:0]  motor_dir;
    logic        pwm;
    logic [7:0]  speed;
    logic        cmd_valid;
    logic        frame_err;
    logic        wdog_stop;
    logic [31:0] num;

    int n_tests;
    int n_fail;
    int hi_cnt;

    car_cmd_ctrl #(
        .HEADER      (8'hA5),
        .TIMEOUT_CYC (50),
        .WDOG_CYC    (2000),
        .PWM_DIV     (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data      (data),
        .rx_done   (rx_done),
        .motor_dir (motor_dir),
        .pwm       (pwm),
        .speed     (speed),
        .cmd_valid (cmd_valid),
        .frame_err (frame_err),
        .wdog_stop (wdog_stop),
        .num       (num)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One-cycle rx_done strobe; returns on the falling edge after capture.
    task automatic send_byte(input logic [7:0] b);
        data    = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        data    = 8'h00;
    endtask

    // Four bytes with one idle cycle between them.
    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
        send_byte(b0);
        @(negedge clk);
        send_byte(b1);
        @(negedge clk);
        send_byte(b2);
        @(negedge clk);
        send_byte(b3);
    endtask

    task automatic count_pwm_period();
        hi_cnt = 0;
        for (int i = 0; i < 255; i++) begin
            @(negedge clk);
            if (pwm === 1'b1) hi_cnt++;
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        data    = 8'h00;
        rx_done = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_dir",   {28'd0, motor_dir}, 32'h0);
        chk("rst_speed", {24'd0, speed},     32'h0);
        chk("rst_num",   num,                32'h0);
        chk("rst_flags", {28'd0, cmd_valid, frame_err, wdog_stop, pwm}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Forward at 0x80.
        send_frame(8'hA5, 8'h01, 8'h80, 8'h81);
        chk("fwd_valid", {31'd0, cmd_valid}, 32'h1);
        chk("fwd_err",   {31'd0, frame_err}, 32'h0);
        chk("fwd_dir",   {28'd0, motor_dir}, 32'hA);
        chk("fwd_speed", {24'd0, speed},     32'h80);
        chk("fwd_num",   num,                32'h0000_0180);
        @(negedge clk);
        chk("fwd_valid_pulse", {31'd0, cmd_valid}, 32'h0);
        count_pwm_period();
        chk("fwd_duty", hi_cnt, 32'd128);

        // Bad checksum: 03+40=43, not 44.
        send_frame(8'hA5, 8'h03, 8'h40, 8'h44);
        chk("badchk_err",   {31'd0, frame_err}, 32'h1);
        chk("badchk_valid", {31'd0, cmd_valid}, 32'h0);
        chk("badchk_dir",   {28'd0, motor_dir}, 32'hA);
        chk("badchk_speed", {24'd0, speed},     32'h80);
        chk("badchk_num",   num,                32'h0000_0180);
        @(negedge clk);
        chk("badchk_err_pulse", {31'd0, frame_err}, 32'h0);

        // Inter-byte timeout after A5 01.
        send_byte(8'hA5);
        @(negedge clk);
        send_byte(8'h01);
        repeat (49) @(negedge clk);
        chk("to_early", {31'd0, frame_err}, 32'h0);
        @(negedge clk);
        chk("to_fire", {31'd0, frame_err}, 32'h1);
        @(negedge clk);
        chk("to_pulse", {31'd0, frame_err}, 32'h0);
        chk("to_dir",   {28'd0, motor_dir}, 32'hA);

        // Back at full speed: 02+FF wraps to 01.
        send_frame(8'hA5, 8'h02, 8'hFF, 8'h01);
        chk("back_valid", {31'd0, cmd_valid}, 32'h1);
        chk("back_dir",   {28'd0, motor_dir}, 32'h5);
        chk("back_speed", {24'd0, speed},     32'hFF);
        chk("back_num",   num,                32'h0000_02FF);
        @(negedge clk);
        count_pwm_period();
        chk("back_duty", hi_cnt, 32'd255);

        // Leading junk is ignored silently.
        send_byte(8'h00);
        chk("junk0_err", {31'd0, frame_err}, 32'h0);
        @(negedge clk);
        send_byte(8'h37);
        chk("junk1_err", {31'd0, frame_err}, 32'h0);
        @(negedge clk);
        // Speed-only frame keeps direction.
        send_frame(8'hA5, 8'h05, 8'h20, 8'h25);
        chk("spd_valid", {31'd0, cmd_valid}, 32'h1);
        chk("spd_speed", {24'd0, speed},     32'h20);
        chk("spd_dir",   {28'd0, motor_dir}, 32'h5);
        chk("spd_num",   num,                32'h0000_0520);
        @(negedge clk);
        // Unknown opcode with a valid checksum.
        send_frame(8'hA5, 8'h07, 8'h00, 8'h07);
        chk("op7_err",   {31'd0, frame_err}, 32'h1);
        chk("op7_valid", {31'd0, cmd_valid}, 32'h0);
        chk("op7_speed", {24'd0, speed},     32'h20);
        chk("op7_num",   num,                32'h0000_0520);
        @(negedge clk);

        // Right turn, then let the watchdog expire.
        send_frame(8'hA5, 8'h04, 8'h10, 8'h14);
        chk("right_dir", {28'd0, motor_dir}, 32'h9);
        chk("right_num", num,                32'h0000_0410);
        repeat (1999) @(negedge clk);
        chk("wd_early_stop", {31'd0, wdog_stop}, 32'h0);
        chk("wd_early_dir",  {28'd0, motor_dir}, 32'h9);
        @(negedge clk);
        chk("wd_stop",  {31'd0, wdog_stop}, 32'h1);
        chk("wd_dir",   {28'd0, motor_dir}, 32'h0);
        repeat (2) @(negedge clk);
        chk("wd_speed", {24'd0, speed},     32'h10);
        chk("wd_pwm",   {31'd0, pwm},       32'h0);
        send_frame(8'hA5, 8'h01, 8'h10, 8'h11);
        chk("wd_clear_stop", {31'd0, wdog_stop}, 32'h0);
        chk("wd_clear_dir",  {28'd0, motor_dir}, 32'hA);
        chk("wd_clear_num",  num,                32'h0000_0110);

        // Asynchronous reset while the FSM waits for VAL.
        @(negedge clk);
        send_byte(8'hA5);
        @(negedge clk);
        send_byte(8'h01);
        #2 rst = 1'b1;
        #1;
        chk("arst_dir",   {28'd0, motor_dir}, 32'h0);
        chk("arst_speed", {24'd0, speed},     32'h0);
        chk("arst_num",   num,                32'h0);
        chk("arst_flags", {28'd0, cmd_valid, frame_err, wdog_stop, pwm}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("arst_no_err", {31'd0, frame_err}, 32'h0);
        send_frame(8'hA5, 8'h01, 8'h05, 8'h06);
        chk("post_valid", {31'd0, cmd_valid}, 32'h1);
        chk("post_dir",   {28'd0, motor_dir}, 32'hA);
        chk("post_speed", {24'd0, speed},     32'h05);
        chk("post_num",   num,                32'h0000_0105);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
